// File: rtl/psram_arbiter_if.sv
// psram_arbiter_if: requester ports A/B plus the PSRAM controller command/data bus
interface psram_arbiter_if;
    logic        req_a, req_b, we_a, we_b;
    logic [23:0] addr_a, addr_b, mem_addr;
    logic [15:0] wdata_a, wdata_b, rdata_a, rdata_b, mem_wdata, mem_rdata;
    logic        ack_a, ack_b, err_a, err_b, mem_wdata_oe, endcommand;
    logic [1:0]  rw;
    modport slave (
        input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_rdata, endcommand,
        output ack_a, ack_b, err_a, err_b, rdata_a, rdata_b, rw, mem_addr, mem_wdata, mem_wdata_oe
    );
    modport master (
        output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_rdata, endcommand,
        input  ack_a, ack_b, err_a, err_b, rdata_a, rdata_b, rw, mem_addr, mem_wdata, mem_wdata_oe
    );
endinterface

// File: rtl/psram_arbiter.sv
// psram_arbiter: round-robin sharing of one PSRAM controller between two requesters
module psram_arbiter #(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11
) (
    input  logic            mem_clk,
    input  logic            rst_n,
    input  logic            qpi_on,
    psram_arbiter_if.slave  bus,
    output logic            busy
);
    localparam int G_W = $clog2(GAP_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, GAP} state_t;
    state_t          state, state_nx;
    logic            sel, last, we, abort, start, grant_b, to_hit;
    logic [TO_W-1:0] tcnt;
    logic [G_W-1:0]  gcnt;
    assign start   = qpi_on & (bus.req_a | bus.req_b);
    assign grant_b = bus.req_b & (~bus.req_a | ~last);
    assign to_hit  = tcnt == TO_W'(TIMEOUT_CYCLES - 1);
    assign busy    = state != IDLE;
    always_ff @(posedge mem_clk)
        state <= !rst_n ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = (bus.endcommand | to_hit) ? DONE : WAIT;
            DONE:    state_nx = GAP;
            GAP:     state_nx = gcnt == G_W'(1) ? IDLE : GAP;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge mem_clk) begin
        if (!rst_n) begin
            sel              <= 1'b0;
            last             <= 1'b1;
            we               <= 1'b0;
            abort            <= 1'b0;
            tcnt             <= '0;
            gcnt             <= '0;
            bus.rw           <= 2'd0;
            bus.mem_addr     <= '0;
            bus.mem_wdata    <= '0;
            bus.mem_wdata_oe <= 1'b0;
            bus.ack_a        <= 1'b0;
            bus.ack_b        <= 1'b0;
            bus.err_a        <= 1'b0;
            bus.err_b        <= 1'b0;
            bus.rdata_a      <= '0;
            bus.rdata_b      <= '0;
        end else begin
            bus.ack_a <= 1'b0;
            bus.ack_b <= 1'b0;
            bus.err_a <= 1'b0;
            bus.err_b <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sel           <= grant_b;
                    last          <= grant_b;
                    we            <= grant_b ? bus.we_b : bus.we_a;
                    bus.mem_addr  <= grant_b ? bus.addr_b : bus.addr_a;
                    bus.mem_wdata <= grant_b ? bus.wdata_b : bus.wdata_a;
                end
                ISSUE: begin
                    bus.rw           <= we ? 2'd1 : 2'd2;
                    bus.mem_wdata_oe <= we;
                    tcnt             <= '0;
                    abort            <= 1'b0;
                end
                WAIT: begin
                    if (bus.endcommand) begin
                        if (!we && sel) bus.rdata_b <= bus.mem_rdata;
                        if (!we && !sel) bus.rdata_a <= bus.mem_rdata;
                    end else if (to_hit) abort <= 1'b1;
                    else tcnt <= tcnt + 1'b1;
                end
                DONE: begin
                    bus.rw           <= 2'd0;
                    bus.mem_wdata_oe <= 1'b0;
                    bus.ack_a        <= ~sel;
                    bus.ack_b        <= sel;
                    bus.err_a        <= ~sel & abort;
                    bus.err_b        <= sel & abort;
                    gcnt             <= G_W'(GAP_CYCLES);
                end
                GAP: gcnt <= gcnt - 1'b1;
                default: ;
            endcase
        end
    end
endmodule
